// File: rtl/lfsr_pos_gen.sv
// Random grid position source: free-running Fibonacci LFSR feeding a rejection sampler.
// Define LFSR_POS_OCCUPANCY_CHECK_EN to add the occ_x/occ_y/occ_hit snake-body lookup stage.
module lfsr_pos_gen #(
    parameter int unsigned       WIDTH     = 12,
    parameter logic [WIDTH-1:0]  TAPS      = 12'h053,
    parameter int unsigned       X_BITS    = 6,
    parameter int unsigned       Y_BITS    = 5,
    parameter int unsigned       X_MAX     = 39,
    parameter int unsigned       Y_MAX     = 29,
    parameter int unsigned       MAX_TRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed,
    input  logic              req,
    output logic              busy,
    output logic              valid,
    output logic [X_BITS-1:0] pos_x,
    output logic [Y_BITS-1:0] pos_y,
    output logic              fail,
    output logic [WIDTH-1:0]  lfsr_state
`ifdef LFSR_POS_OCCUPANCY_CHECK_EN
    ,
    output logic [X_BITS-1:0] occ_x,
    output logic [Y_BITS-1:0] occ_y,
    input  logic              occ_hit
`endif
);

    localparam int unsigned      TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {IDLE, DRAW, CHECK, DONE} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_lfsr;
    logic [TRY_W-1:0]   r_try;
    logic               r_busy;
    logic               r_valid;
    logic               r_fail;
    logic [X_BITS-1:0]  r_pos_x;
    logic [Y_BITS-1:0]  r_pos_y;

    logic               w_feedback;
    logic [X_BITS-1:0]  w_cx;
    logic [Y_BITS-1:0]  w_cy;
    logic               w_in_range;
    logic               w_last_try;

    assign w_feedback = ^(r_lfsr & TAPS);
    assign w_cx       = r_lfsr[X_BITS-1:0];
    assign w_cy       = r_lfsr[X_BITS+Y_BITS-1:X_BITS];
    assign w_in_range = (32'(w_cx) <= X_MAX) && (32'(w_cy) <= Y_MAX);
    assign w_last_try = (r_try == LAST_TRY);

    // The LFSR runs in every state so the drawn value depends on when req arrives.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments in clocked blocks keep every register
        // sampling pre-edge values, so ordering between blocks never matters.
        if (!rst) begin
            r_lfsr <= WIDTH'(1);
        end else if (seed_load) begin
            r_lfsr <= (seed == '0) ? WIDTH'(1) : seed;
        end else if (r_lfsr == '0) begin
            r_lfsr <= WIDTH'(1);
        end else begin
            r_lfsr <= {w_feedback, r_lfsr[WIDTH-1:1]};
        end
    end

`ifdef LFSR_POS_OCCUPANCY_CHECK_EN
    logic [X_BITS-1:0] r_cand_x;
    logic [Y_BITS-1:0] r_cand_y;

    assign occ_x = r_cand_x;
    assign occ_y = r_cand_y;
`endif

    // Outputs are written on entry to DONE so valid and the new position appear together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_try   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_fail  <= 1'b0;
            r_pos_x <= '0;
            r_pos_y <= '0;
`ifdef LFSR_POS_OCCUPANCY_CHECK_EN
            r_cand_x <= '0;
            r_cand_y <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_state <= DRAW;
                        r_busy  <= 1'b1;
                        r_try   <= '0;
                    end
                end
                DRAW: begin
`ifdef LFSR_POS_OCCUPANCY_CHECK_EN
                    r_cand_x <= w_cx;
                    r_cand_y <= w_cy;
`endif
                    if (w_in_range) begin
`ifdef LFSR_POS_OCCUPANCY_CHECK_EN
                        r_state <= CHECK;
`else
                        r_state <= DONE;
                        r_valid <= 1'b1;
                        r_fail  <= 1'b0;
                        r_pos_x <= w_cx;
                        r_pos_y <= w_cy;
`endif
                    end else if (w_last_try) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                        r_fail  <= 1'b1;
                        r_pos_x <= '0;
                        r_pos_y <= '0;
                    end else begin
                        r_try <= r_try + TRY_W'(1);
                    end
                end
`ifdef LFSR_POS_OCCUPANCY_CHECK_EN
                CHECK: begin
                    if (!occ_hit) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                        r_fail  <= 1'b0;
                        r_pos_x <= r_cand_x;
                        r_pos_y <= r_cand_y;
                    end else if (w_last_try) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                        r_fail  <= 1'b1;
                        r_pos_x <= '0;
                        r_pos_y <= '0;
                    end else begin
                        r_state <= DRAW;
                        r_try   <= r_try + TRY_W'(1);
                    end
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign valid      = r_valid;
    assign fail       = r_fail;
    assign pos_x      = r_pos_x;
    assign pos_y      = r_pos_y;
    assign lfsr_state = r_lfsr;

endmodule

// File: tb/tb_lfsr_pos_gen.sv
// Self-checking bench for lfsr_pos_gen: directed and random draws against a
// behavioural model, run on instances with MAX_TRIES = 16 and 1 (and 4 with occupancy).
module tb_lfsr_pos_gen;

    localparam int W  = 12;
    localparam int XB = 6;
    localparam int YB = 5;
`ifdef LFSR_POS_OCCUPANCY_CHECK_EN
    localparam int NDUT = 3;
`else
    localparam int NDUT = 2;
`endif
    localparam int MT [3] = '{16, 1, 4};
    // Occupancy mode per instance: 0 never hit, 1 hit only at (37,2), 2 always hit.
    localparam int OM [3] = '{1, 0, 2};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          seed_load = 1'b0;
    logic          req = 1'b0;
    logic [W-1:0]  seed = '0;

    logic          bz [NDUT];
    logic          v  [NDUT];
    logic          f  [NDUT];
    logic [XB-1:0] px [NDUT];
    logic [YB-1:0] py [NDUT];
    logic [W-1:0]  ls [NDUT];

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int m_lfsr = 1;
    int pxp [NDUT];
    int pyp [NDUT];
    int pfp [NDUT];

    always #5 clk = ~clk;

`ifdef LFSR_POS_OCCUPANCY_CHECK_EN
    logic [XB-1:0] ox [NDUT];
    logic [YB-1:0] oy [NDUT];
    logic          oh [NDUT];
    assign oh[0] = (ox[0] == 6'd37) && (oy[0] == 5'd2);
    assign oh[1] = 1'b0;
    assign oh[2] = 1'b1;
`endif

    lfsr_pos_gen #(.MAX_TRIES(16)) u_dut_a (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
        .busy(bz[0]), .valid(v[0]), .pos_x(px[0]), .pos_y(py[0]), .fail(f[0]),
        .lfsr_state(ls[0])
`ifdef LFSR_POS_OCCUPANCY_CHECK_EN
        , .occ_x(ox[0]), .occ_y(oy[0]), .occ_hit(oh[0])
`endif
    );

    lfsr_pos_gen #(.MAX_TRIES(1)) u_dut_b (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
        .busy(bz[1]), .valid(v[1]), .pos_x(px[1]), .pos_y(py[1]), .fail(f[1]),
        .lfsr_state(ls[1])
`ifdef LFSR_POS_OCCUPANCY_CHECK_EN
        , .occ_x(ox[1]), .occ_y(oy[1]), .occ_hit(oh[1])
`endif
    );

`ifdef LFSR_POS_OCCUPANCY_CHECK_EN
    lfsr_pos_gen #(.MAX_TRIES(4)) u_dut_c (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
        .busy(bz[2]), .valid(v[2]), .pos_x(px[2]), .pos_y(py[2]), .fail(f[2]),
        .lfsr_state(ls[2]), .occ_x(ox[2]), .occ_y(oy[2]), .occ_hit(oh[2])
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Next LFSR value: shift right, new MSB is the parity of the tapped bits (mask 0x053).
    function automatic int step(input int s);
        return (s >> 1) + (($countones(s & 'h053) % 2) << 11);
    endfunction

    function automatic bit occupied(input int x, input int y, input int mode);
        return (mode == 2) || (mode == 1 && x == 37 && y == 2);
    endfunction

    // Outcome of a draw whose first candidate is s1 (seen in cycle 1 after req).
    function automatic void predict(input int s1, input int max_tries, input int mode,
                                    output int ex, output int ey, output int ef, output int el);
        int s;
        int cyc;
        int x;
        int y;
        bit ok;
        s   = s1;
        cyc = 1;
        for (int t = 0; t < max_tries; t++) begin
            x  = s % 64;
            y  = (s / 64) % 32;
            ok = (x <= 39) && (y <= 29);
`ifdef LFSR_POS_OCCUPANCY_CHECK_EN
            if (ok) begin
                if (!occupied(x, y, mode)) begin
                    ex = x; ey = y; ef = 0; el = cyc + 2;
                    return;
                end
                cyc += 2;
                s = step(step(s));
            end else begin
                cyc += 1;
                s = step(s);
            end
`else
            if (ok && !occupied(x, y, mode & 0)) begin
                ex = x; ey = y; ef = 0; el = cyc + 1;
                return;
            end
            cyc += 1;
            s = step(s);
`endif
        end
        ex = 0; ey = 0; ef = 1; el = cyc;
    endfunction

    task automatic tick();
        if (seed_load) m_lfsr = (seed == '0) ? 1 : int'(seed);
        else if (m_lfsr == 0) m_lfsr = 1;
        else m_lfsr = step(m_lfsr);
        @(posedge clk);
        #1;
    endtask

    task automatic run_draw(input bit do_seed, input logic [W-1:0] sv, input string tag);
        int ex [NDUT];
        int ey [NDUT];
        int ef [NDUT];
        int el [NDUT];
        int last;
        bit after;
        seed_load = do_seed;
        seed      = sv;
        req       = 1'b1;
        tick();
        seed_load = 1'b0;
        req       = 1'b0;
        last = 0;
        for (int d = 0; d < NDUT; d++) begin
            predict(m_lfsr, MT[d], OM[d], ex[d], ey[d], ef[d], el[d]);
            if (el[d] > last) last = el[d];
        end
        for (int c = 1; c <= last + 1; c++) begin
            for (int d = 0; d < NDUT; d++) begin
                after = (c >= el[d]);
                check($sformatf("%s_valid_d%0d_c%0d", tag, d, c), 32'(v[d]), 32'(c == el[d]));
                check($sformatf("%s_busy_d%0d_c%0d", tag, d, c), 32'(bz[d]), 32'(c <= el[d]));
                check($sformatf("%s_x_d%0d_c%0d", tag, d, c), 32'(px[d]), after ? ex[d] : pxp[d]);
                check($sformatf("%s_y_d%0d_c%0d", tag, d, c), 32'(py[d]), after ? ey[d] : pyp[d]);
                check($sformatf("%s_fail_d%0d_c%0d", tag, d, c), 32'(f[d]), after ? ef[d] : pfp[d]);
                check($sformatf("%s_lfsr_d%0d_c%0d", tag, d, c), 32'(ls[d]), m_lfsr);
            end
            tick();
        end
        for (int d = 0; d < NDUT; d++) begin
            pxp[d] = ex[d];
            pyp[d] = ey[d];
            pfp[d] = ef[d];
        end
    endtask

    initial begin
        logic [W-1:0] rs;
        bit           rds;
        int           gap;
        int           next_acc;
        int           vcyc;
        int           nv_exp;
        int           nv_obs;
        int           hx, hy, hf, hl;
        int           free_run [4];

        free_run = '{'h001, 'h800, 'h400, 'h200};
        for (int d = 0; d < NDUT; d++) begin
            pxp[d] = 0; pyp[d] = 0; pfp[d] = 0;
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_lfsr_d%0d", d), 32'(ls[d]), 32'h001);
            check($sformatf("rst_valid_d%0d", d), 32'(v[d]), 0);
            check($sformatf("rst_busy_d%0d", d), 32'(bz[d]), 0);
            check($sformatf("rst_pos_d%0d", d), 32'({px[d], py[d]}), 0);
            check($sformatf("rst_fail_d%0d", d), 32'(f[d]), 0);
        end
        rst    = 1'b1;
        m_lfsr = 1;

        // Free-running sequence from the reset value.
        for (int i = 0; i < 4; i++) begin
            check($sformatf("free_lfsr_%0d", i), 32'(ls[0]), free_run[i]);
            check($sformatf("free_valid_%0d", i), 32'(v[0]), 0);
            check($sformatf("free_busy_%0d", i), 32'(bz[0]), 0);
            check($sformatf("free_pos_%0d", i), 32'({px[0], py[0]}), 0);
            if (i < 3) tick();
        end

        // Directed draws: immediate accept, one rejection, MAX_TRIES = 1 fail, recovery.
        run_draw(1'b1, 12'h0A5, "seed_0a5");
`ifndef LFSR_POS_OCCUPANCY_CHECK_EN
        check("dir_0a5_x", 32'(px[0]), 37);
        check("dir_0a5_y", 32'(py[0]), 2);
        check("dir_0a5_fail", 32'(f[0]), 0);
`endif
        run_draw(1'b1, 12'h03F, "seed_03f");
`ifndef LFSR_POS_OCCUPANCY_CHECK_EN
        check("dir_03f_x", 32'(px[0]), 31);
        check("dir_03f_y", 32'(py[0]), 0);
        check("dir_03f_b_fail", 32'(f[1]), 1);
        check("dir_03f_b_pos", 32'({px[1], py[1]}), 0);
`endif
        run_draw(1'b1, 12'h0A5, "seed_0a5_again");
`ifndef LFSR_POS_OCCUPANCY_CHECK_EN
        check("dir_recover_b_fail", 32'(f[1]), 0);
        check("dir_recover_b_x", 32'(px[1]), 37);
        check("dir_recover_b_y", 32'(py[1]), 2);
`else
        check("occ_c_fail", 32'(f[2]), 1);
        check("occ_a_fail", 32'(f[0]), 0);
`endif

        // Random draws with random idle gaps, seeded and unseeded.
        for (int i = 0; i < 30; i++) begin
            gap = $urandom_range(0, 3);
            rs  = W'($urandom);
            rds = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) rs = '0;
            for (int g = 0; g < gap; g++) begin
                tick();
                check($sformatf("gap_lfsr_%0d_%0d", i, g), 32'(ls[0]), m_lfsr);
            end
            run_draw(rds, rs, $sformatf("rnd%0d", i));
        end

        // req held high: each IDLE acceptance yields exactly one valid.
        next_acc = 0;
        vcyc     = -1;
        nv_exp   = 0;
        nv_obs   = 0;
        hx = 0; hy = 0; hf = 0; hl = 0;
        for (int c = 0; c < 72; c++) begin
            req = (c < 40);
            check($sformatf("hold_valid_c%0d", c), 32'(v[0]), 32'(c == vcyc));
            if (c == vcyc) begin
                check($sformatf("hold_pos_c%0d", c), 32'({px[0], py[0]}), (hx << YB) | hy);
                check($sformatf("hold_fail_c%0d", c), 32'(f[0]), hf);
            end
            if (v[0]) nv_obs++;
            if (c == next_acc) begin
                if (req) begin
                    predict(step(m_lfsr), MT[0], OM[0], hx, hy, hf, hl);
                    vcyc     = c + hl;
                    next_acc = vcyc + 1;
                    nv_exp++;
                end else begin
                    next_acc = c + 1;
                end
            end
            tick();
        end
        req = 1'b0;
        check("hold_valid_count", nv_obs, nv_exp);

        // Zero seed recovers to 1.
        seed_load = 1'b1;
        seed      = '0;
        tick();
        seed_load = 1'b0;
        check("seed_zero_lfsr", 32'(ls[0]), 32'h001);

        // Reset mid-draw abandons the draw immediately.
        seed_load = 1'b1;
        seed      = 12'h03F;
        req       = 1'b1;
        tick();
        seed_load = 1'b0;
        req       = 1'b0;
        check("mid_busy_before_rst", 32'(bz[0]), 1);
        #2;
        rst = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("mid_rst_busy_d%0d", d), 32'(bz[d]), 0);
            check($sformatf("mid_rst_valid_d%0d", d), 32'(v[d]), 0);
            check($sformatf("mid_rst_lfsr_d%0d", d), 32'(ls[d]), 32'h001);
            check($sformatf("mid_rst_pos_d%0d", d), 32'({px[d], py[d]}), 0);
            check($sformatf("mid_rst_fail_d%0d", d), 32'(f[d]), 0);
            pxp[d] = 0; pyp[d] = 0; pfp[d] = 0;
        end
        #2;
        rst    = 1'b1;
        m_lfsr = 1;
        @(posedge clk);
        #1;
        m_lfsr = step(m_lfsr);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("post_rst_valid_c%0d", c), 32'(v[0]), 0);
            check($sformatf("post_rst_busy_c%0d", c), 32'(bz[0]), 0);
            check($sformatf("post_rst_lfsr_c%0d", c), 32'(ls[0]), m_lfsr);
            tick();
        end
        run_draw(1'b1, 12'h0A5, "post_rst_draw");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lfsr_pos_gen.md
Name: lfsr_pos_gen

Overview:
- Parametrised Galois-free (Fibonacci, right-shift) LFSR random source with a request/valid front end.
- Produces a random in-range grid coordinate (food/obstacle placement) for the snake game controller.
- Rejection-samples out-of-range candidates.
- Supports runtime seeding and zero-state lock-up recovery.

Parameters:
- WIDTH, 12, LFSR width in bits.
- TAPS, 12'h053, feedback tap mask; must be WIDTH bits wide.
- X_BITS, 6, width of the pos_x field.
- Y_BITS, 5, width of the pos_y field; X_BITS+Y_BITS <= WIDTH.
- X_MAX, 39, largest legal x (grid is 40 columns).
- Y_MAX, 29, largest legal y (grid is 30 rows).
- MAX_TRIES, 16, rejected candidates allowed before giving up; range 1..255.

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- seed_load, in, 1, load seed into the LFSR this cycle.
- seed, in, WIDTH, seed value.
- req, in, 1, request a new position; sampled only in IDLE.
- busy, out, 1, high while state != IDLE.
- valid, out, 1, one-cycle pulse when pos_x/pos_y/fail are updated.
- pos_x, out, X_BITS, accepted x coordinate; held until the next valid.
- pos_y, out, Y_BITS, accepted y coordinate; held until the next valid.
- fail, out, 1, set with valid when MAX_TRIES is exhausted; held until the next valid.
- lfsr_state, out, WIDTH, current LFSR value (debug).

Behaviour:
- Reset (rst low, asynchronous):
  - lfsr = 1; pos_x = 0; pos_y = 0; valid = 0; fail = 0.
  - State IDLE; try counter = 0.
  - Applies mid-operation too: any draw in progress is abandoned, with no valid.
- LFSR update, every clk cycle, in priority order:
  - seed_load = 1: lfsr <= seed, or 1 if seed == 0.
  - else lfsr == 0: lfsr <= 1 (lock-up recovery).
  - else lfsr <= {^(lfsr & TAPS), lfsr[WIDTH-1:1]}.
  - The LFSR free-runs in all states, so entropy comes from request timing.
- Candidate, taken from the current lfsr value:
  - cx = lfsr[X_BITS-1:0]
  - cy = lfsr[X_BITS+Y_BITS-1:X_BITS]
  - Compares are unsigned: in range iff cx <= X_MAX and cy <= Y_MAX.
- State machine (states IDLE, DRAW, CHECK, DONE):
  - IDLE: req = 1 -> DRAW; try counter cleared. req outside IDLE is ignored (not queued).
  - DRAW: register cx/cy into cand.
    - In range -> CHECK if the optional feature is compiled in, else DONE.
    - Out of range: if try == MAX_TRIES-1 -> DONE with fail; else try++ and stay in DRAW (next cycle uses the next lfsr).
  - CHECK: optional feature only; see below.
  - DONE:
    - valid = 1 for exactly one cycle.
    - pos_x/pos_y <= cand on success; on fail, pos_x/pos_y <= 0 and fail <= 1.
    - fail <= 0 on success.
    - -> IDLE.
- Latency:
  - req in cycle 0 and first candidate accepted: valid in cycle 2.
  - Each rejection adds 1 cycle.
  - Worst case is MAX_TRIES+1 cycles after req (plus the CHECK cycles if enabled).
- busy:
  - Registered, = (state != IDLE).
  - High from cycle 1 through the valid cycle inclusive.
- seed_load with req in the same cycle: DRAW sees the seed value (no step in the load cycle).
- seed_load during DRAW: takes effect on the next candidate; the draw continues.
- Try counter is ceil(log2(MAX_TRIES+1)) bits wide and never wraps; it saturates into the fail path.

Optional Feature:
- Macro: LFSR_POS_OCCUPANCY_CHECK_EN.
- Defined: adds ports:
  - occ_x out X_BITS and occ_y out Y_BITS, both = cand.
  - occ_hit in 1, combinational snake-body lookup, valid during CHECK.
- CHECK state:
  - occ_hit = 0 -> DONE.
  - occ_hit = 1 counts as a rejection: try == MAX_TRIES-1 -> DONE with fail; else try++ -> DRAW.
- Undefined: no occ ports; in-range candidates go directly DRAW -> DONE.

Test Plan:
1. Reset then free-run, no seed_load -> lfsr_state sequence 0x001, 0x800, 0x400, 0x200.
   - valid = 0 and busy = 0 throughout; pos = (0,0).
2. seed_load = 1 with seed = 0x0A5 and req = 1 in cycle 0:
   - cycle 1 DRAW, candidate (37,2) accepted.
   - cycle 2: valid = 1, pos = (37,2), fail = 0.
   - cycle 3: valid = 0, busy = 0.
3. seed = 0x03F with req in the same cycle:
   - candidate (63,0) rejected; next lfsr 0x81F gives (31,0), accepted.
   - valid in cycle 3 with pos = (31,0).
4. MAX_TRIES = 1, seed = 0x03F with req:
   - valid in cycle 2 with fail = 1 and pos = (0,0).
   - Following req after seed 0x0A5 -> fail = 0, pos = (37,2).
5. seed_load seed = 0 -> lfsr_state = 0x001.
   - rst pulsed low during DRAW -> no valid; busy = 0 immediately; lfsr = 0x001.
   - req held high while busy -> exactly one valid per IDLE acceptance.
6. With LFSR_POS_OCCUPANCY_CHECK_EN, seed 0x0A5 with req:
   - occ_hit = 1 when occ = (37,2) -> redraw.
   - Next accepted free candidate reported with valid; occ_hit tied to 1 with MAX_TRIES = 4 -> fail = 1.
